// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter
//   Buffers one completed result per functional unit and broadcasts up to
//   N_CDB of them per cycle on registered common-data-bus lanes. These lanes
//   feed the register file write ports and the RS/ROB wakeup logic.
//
//   Optional feature macro: CDB_ROUND_ROBIN_EN
//     defined   -> rotating priority starting at rr_ptr
//     undefined -> fixed priority, FU0 highest
//
// Ports
//   i_clock       system clock, posedge
//   i_reset       asynchronous, active-high reset
//   i_squash      synchronous flush: empties every slot and every lane
//   i_fu_valid    per-FU result valid
//   i_fu_tag      per-FU destination physical tag (flat, FU i at [i*PR_W +: PR_W])
//   i_fu_data     per-FU result data (flat, FU i at [i*XLEN +: XLEN])
//   o_fu_ready    per-FU slot accepts this cycle (combinational, independent of valid)
//   o_cdb_valid   per-lane broadcast valid
//   o_cdb_tag     per-lane tag, ZERO_PR when idle
//   o_cdb_data    per-lane data, 0 when idle
module cdb_broadcast_arbiter #(
   parameter int N_FU  = 6,
   parameter int N_CDB = 3,
   parameter int PR_W  = 6,
   parameter int XLEN  = 32
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_squash,
   input  logic [N_FU-1:0]         i_fu_valid,
   input  logic [N_FU*PR_W-1:0]    i_fu_tag,
   input  logic [N_FU*XLEN-1:0]    i_fu_data,
   output logic [N_FU-1:0]         o_fu_ready,
   output logic [N_CDB-1:0]        o_cdb_valid,
   output logic [N_CDB*PR_W-1:0]   o_cdb_tag,
   output logic [N_CDB*XLEN-1:0]   o_cdb_data
);

   localparam int PTR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
   localparam int LANE_W = $clog2(N_CDB + 1);
   localparam logic [PR_W-1:0] ZERO_PR = '0;

   // Result slots, one per FU
   logic [N_FU-1:0]  r_occ;
   logic [PR_W-1:0]  r_tag  [N_FU];
   logic [XLEN-1:0]  r_data [N_FU];

   // Registered CDB lanes
   logic [N_CDB-1:0]      r_cdb_valid;
   logic [N_CDB*PR_W-1:0] r_cdb_tag;
   logic [N_CDB*XLEN-1:0] r_cdb_data;

   // Arbitration results
   logic [N_FU-1:0]   w_grant;
   logic [N_CDB-1:0]  w_lane_valid;
   logic [PR_W-1:0]   w_lane_tag  [N_CDB];
   logic [XLEN-1:0]   w_lane_data [N_CDB];
   logic [LANE_W-1:0] w_lane_cnt;
   logic [PTR_W:0]    w_sum;
   logic [PTR_W-1:0]  w_idx;
   logic [PTR_W-1:0]  w_base;

`ifdef CDB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] r_rr_ptr;
   logic [PTR_W-1:0] w_next_ptr;
   logic             w_lane_any;
   assign w_base = r_rr_ptr;
`else
   assign w_base = '0;
`endif

   // Walk slots in priority order starting at w_base. Zero-tag slots are
   // drained without consuming a lane; others take lanes 0,1,.. in order.
   always_comb begin
      w_grant      = '0;
      w_lane_valid = '0;
      w_lane_cnt   = '0;
      w_sum        = '0;
      w_idx        = '0;
      for (int k = 0; k < N_CDB; k++) begin
         w_lane_tag[k]  = ZERO_PR;
         w_lane_data[k] = '0;
      end
`ifdef CDB_ROUND_ROBIN_EN
      w_next_ptr = r_rr_ptr;
      w_lane_any = 1'b0;
`endif
      for (int p = 0; p < N_FU; p++) begin
         w_sum = {1'b0, w_base} + (PTR_W+1)'(p);
         if (w_sum >= (PTR_W+1)'(N_FU)) begin
            w_sum = w_sum - (PTR_W+1)'(N_FU);
         end
         w_idx = w_sum[PTR_W-1:0];
         if (r_occ[w_idx]) begin
            if (r_tag[w_idx] == ZERO_PR) begin
               w_grant[w_idx] = 1'b1;
            end else if (w_lane_cnt < LANE_W'(N_CDB)) begin
               w_grant[w_idx]          = 1'b1;
               w_lane_valid[w_lane_cnt] = 1'b1;
               w_lane_tag[w_lane_cnt]   = r_tag[w_idx];
               w_lane_data[w_lane_cnt]  = r_data[w_idx];
               w_lane_cnt               = w_lane_cnt + 1'b1;
`ifdef CDB_ROUND_ROBIN_EN
               w_lane_any = 1'b1;
               w_next_ptr = (w_idx == PTR_W'(N_FU - 1)) ? '0 : w_idx + 1'b1;
`endif
            end
         end
      end
   end

   // A slot frees up when empty or drained this cycle; never during squash
   always_comb begin
      o_fu_ready = {N_FU{~i_squash}} & (~r_occ | w_grant);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_occ       <= '0;
         r_cdb_valid <= '0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
         for (int i = 0; i < N_FU; i++) begin
            r_tag[i]  <= ZERO_PR;
            r_data[i] <= '0;
         end
      end else if (i_squash) begin
         r_occ       <= '0;
         r_cdb_valid <= '0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
      end else begin
         r_cdb_valid <= w_lane_valid;
         for (int k = 0; k < N_CDB; k++) begin
            r_cdb_tag[k*PR_W +: PR_W]  <= w_lane_tag[k];
            r_cdb_data[k*XLEN +: XLEN] <= w_lane_data[k];
         end
         for (int i = 0; i < N_FU; i++) begin
            // A new write wins over the drain of the old entry
            if (i_fu_valid[i] && o_fu_ready[i]) begin
               r_occ[i]  <= 1'b1;
               r_tag[i]  <= i_fu_tag[i*PR_W +: PR_W];
               r_data[i] <= i_fu_data[i*XLEN +: XLEN];
            end else if (w_grant[i]) begin
               r_occ[i] <= 1'b0;
            end
         end
      end
   end

`ifdef CDB_ROUND_ROBIN_EN
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_rr_ptr <= '0;
      end else if (!i_squash && w_lane_any) begin
         r_rr_ptr <= w_next_ptr;
      end
   end
`endif

   assign o_cdb_valid = r_cdb_valid;
   assign o_cdb_tag   = r_cdb_tag;
   assign o_cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Testbench for cdb_broadcast_arbiter: directed vector table, a reset
// mid-run sequence and randomized traffic against a queue-based model.
module tb_cdb_broadcast_arbiter;

   localparam int N_FU  = 6;
   localparam int N_CDB = 3;

   typedef logic [5:0][5:0]  tag6_t;
   typedef logic [5:0][31:0] data6_t;
   typedef logic [2:0][5:0]  tag3_t;
   typedef logic [2:0][31:0] data3_t;

   typedef struct {
      logic        sq;
      logic [5:0]  v;
      tag6_t       tag;
      data6_t      data;
      logic [5:0]  rdy;
      logic [2:0]  cv;
      tag3_t       ct;
      data3_t      cd;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       squash;
   logic [5:0] fu_valid;
   tag6_t      fu_tag;
   data6_t     fu_data;
   logic [5:0] fu_ready;
   logic [2:0] cdb_valid;
   tag3_t      cdb_tag;
   data3_t     cdb_data;

   int checks = 0;
   int errors = 0;

   cdb_broadcast_arbiter u_dut (
      .i_clock    (clock),
      .i_reset    (reset),
      .i_squash   (squash),
      .i_fu_valid (fu_valid),
      .i_fu_tag   (fu_tag),
      .i_fu_data  (fu_data),
      .o_fu_ready (fu_ready),
      .o_cdb_valid(cdb_valid),
      .o_cdb_tag  (cdb_tag),
      .o_cdb_data (cdb_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic tag6_t t6(input int a0, a1, a2, a3, a4, a5);
      return {6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
   endfunction
   function automatic data6_t d6(input int a0, a1, a2, a3, a4, a5);
      return {32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
   endfunction
   function automatic tag3_t t3(input int l0, l1, l2);
      return {6'(l2), 6'(l1), 6'(l0)};
   endfunction
   function automatic data3_t d3(input int l0, l1, l2);
      return {32'(l2), 32'(l1), 32'(l0)};
   endfunction

   vec_t vecs[$];

   task automatic add(input logic sq, input logic [5:0] v, input tag6_t tag, input data6_t data,
                      input logic [5:0] rdy, input logic [2:0] cv, input tag3_t ct,
                      input data3_t cd);
      vec_t x;
      x.sq = sq; x.v = v; x.tag = tag; x.data = data;
      x.rdy = rdy; x.cv = cv; x.ct = ct; x.cd = cd;
      vecs.push_back(x);
   endtask

   // ---------------- reference model ----------------
   bit          m_occ  [N_FU];
   logic [5:0]  m_tag  [N_FU];
   logic [31:0] m_data [N_FU];
   logic [5:0]  m_grant;
   int          m_win[$];
   int          m_ptr;
   logic [2:0]  m_cv;
   tag3_t       m_ct;
   data3_t      m_cd;

   function automatic void m_reset();
      for (int i = 0; i < N_FU; i++) m_occ[i] = 0;
      m_ptr = 0; m_cv = '0; m_ct = '0; m_cd = '0;
   endfunction

   // Priority order is the slot list rotated to start at m_ptr; the first
   // N_CDB occupied nonzero-tag slots win, zero-tag slots always drain.
   function automatic void m_arbitrate();
      int order[$];
      m_grant = '0;
      m_win.delete();
      for (int k = 0; k < N_FU; k++) order.push_back((m_ptr + k) % N_FU);
      foreach (order[j]) begin
         int f = order[j];
         if (m_occ[f]) begin
            if (m_tag[f] == 6'd0) m_grant[f] = 1'b1;
            else if (m_win.size() < N_CDB) begin
               m_win.push_back(f);
               m_grant[f] = 1'b1;
            end
         end
      end
   endfunction

   task automatic cycle_rand(input int n);
      logic sq;
      logic [5:0] v, er;
      tag6_t t;
      data6_t d;
      sq = ($urandom_range(0, 19) == 0);
      v  = 6'($urandom);
      for (int i = 0; i < N_FU; i++) begin
         t[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         d[i] = $urandom;
      end
      m_arbitrate();
      for (int i = 0; i < N_FU; i++) er[i] = !sq && (!m_occ[i] || m_grant[i]);
      squash = sq; fu_valid = v; fu_tag = t; fu_data = d;
      #1;
      chk($sformatf("rand%0d ready", n), fu_ready, er);
      @(posedge clock); #1;
      m_cv = '0; m_ct = '0; m_cd = '0;
      if (sq) begin
         for (int i = 0; i < N_FU; i++) m_occ[i] = 0;
      end else begin
         foreach (m_win[k]) begin
            m_cv[k] = 1'b1;
            m_ct[k] = m_tag[m_win[k]];
            m_cd[k] = m_data[m_win[k]];
         end
`ifdef CDB_ROUND_ROBIN_EN
         if (m_win.size() > 0) m_ptr = (m_win[m_win.size()-1] + 1) % N_FU;
`endif
         for (int i = 0; i < N_FU; i++) begin
            if (v[i] && er[i]) begin
               m_occ[i] = 1; m_tag[i] = t[i]; m_data[i] = d[i];
            end else if (m_grant[i]) begin
               m_occ[i] = 0;
            end
         end
      end
      chk($sformatf("rand%0d cdb_valid", n), cdb_valid, m_cv);
      chk($sformatf("rand%0d cdb_tag", n), cdb_tag, m_ct);
      chk($sformatf("rand%0d cdb_data", n), cdb_data, m_cd);
   endtask

   task automatic do_reset();
      reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      m_reset();
   endtask

   initial begin
      tag6_t  z6t = '0;
      data6_t z6d = '0;
      tag3_t  z3t = '0;
      data3_t z3d = '0;

      // Rows: inputs this cycle, expected ready this cycle, expected lanes after the edge
      add(0, 6'h3F, t6(1,2,3,4,5,6), d6('h101,'h102,'h103,'h104,'h105,'h106), 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h00, z6t, z6d, 6'h07, 3'b111, t3(1,2,3), d3('h101,'h102,'h103));
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b111, t3(4,5,6), d3('h104,'h105,'h106));
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h09, t6(5,0,0,9,0,0), d6('hAA,0,0,'hBB,0,0), 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b011, t3(5,9,0), d3('hAA,'hBB,0));
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h14, t6(0,0,0,0,7,0), d6(0,0,'h100,0,'h107,0), 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b001, t3(7,0,0), d3('h107,0,0));
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h01, t6(10,0,0,0,0,0), d6('h10A,0,0,0,0,0), 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h01, t6(11,0,0,0,0,0), d6('h10B,0,0,0,0,0), 6'h3F, 3'b001, t3(10,0,0), d3('h10A,0,0));
      add(0, 6'h01, t6(12,0,0,0,0,0), d6('h10C,0,0,0,0,0), 6'h3F, 3'b001, t3(11,0,0), d3('h10B,0,0));
      add(0, 6'h38, t6(0,0,0,23,24,25), d6(0,0,0,'h117,'h118,'h119), 6'h3F, 3'b001, t3(12,0,0), d3('h10C,0,0));
      add(1, 6'h02, t6(0,30,0,0,0,0), d6(0,'h11E,0,0,0,0), 6'h00, 3'b000, z3t, z3d);
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b000, z3t, z3d);
      add(0, 6'h00, z6t, z6d, 6'h3F, 3'b000, z3t, z3d);

      do_reset();
      chk("reset cdb_valid", cdb_valid, 3'b000);
      chk("reset cdb_tag", cdb_tag, z3t);
      chk("reset cdb_data", cdb_data, z3d);
      chk("reset fu_ready", fu_ready, 6'h3F);

      foreach (vecs[k]) begin
         squash = vecs[k].sq; fu_valid = vecs[k].v;
         fu_tag = vecs[k].tag; fu_data = vecs[k].data;
         #1;
         chk($sformatf("vec%0d ready", k), fu_ready, vecs[k].rdy);
         @(posedge clock); #1;
         chk($sformatf("vec%0d cdb_valid", k), cdb_valid, vecs[k].cv);
         chk($sformatf("vec%0d cdb_tag", k), cdb_tag, vecs[k].ct);
         chk($sformatf("vec%0d cdb_data", k), cdb_data, vecs[k].cd);
      end

      // Reset mid-run with slots occupied and live lanes
      squash = 0; fu_valid = 6'h0F;
      fu_tag = t6(40,41,42,43,0,0); fu_data = d6('h140,'h141,'h142,'h143,0,0);
      @(posedge clock); #1;
      fu_valid = 6'h07; fu_tag = t6(44,45,46,0,0,0); fu_data = d6('h144,'h145,'h146,0,0,0);
      @(posedge clock); #1;
      fu_valid = '0;
      chk("prereset cdb_valid", cdb_valid, 3'b111);
      #3 reset = 1'b1;
      #1;
      chk("async reset cdb_valid", cdb_valid, 3'b000);
      chk("async reset cdb_tag", cdb_tag, z3t);
      chk("async reset cdb_data", cdb_data, z3d);
      @(posedge clock); #1 reset = 1'b0;
      #1;
      chk("postreset fu_ready", fu_ready, 6'h3F);
      @(posedge clock); #1;
      chk("postreset cdb_valid", cdb_valid, 3'b000);
      m_reset();

      for (int n = 0; n < 400; n++) cycle_rand(n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
